instr_fetch_ctrl: RTL and testbench

Fetch sequencer for the byte-addressed instruction memory. Owns the fetch PC, drives the memory address, captures the combinationally returned 32-bit big-endian instruction word, and buffers it in a small queue toward decode with a valid/ready handshake. Handles taken-branch/jump redirects with queue flush, and stops with a fault on out-of-range (and optionally misaligned) fetch addresses.

---
 rtl/instr_fetch_ctrl.sv | 142 ++++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, queues big-endian words toward decode,
// handles redirects and address faults. Define IFETCH_ALIGN_CHECK_EN to fault on misaligned PCs.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int unsigned MEM_BYTES = 28,
  parameter int unsigned QDEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [1:0]  fault_cause,
  output logic        busy
);

  localparam int CW = $clog2(QDEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic [31:0]   q_data [QDEPTH];
  logic [31:0]   q_pc   [QDEPTH];
  logic [CW-1:0] count;
  logic [CW-1:0] wr_idx;
  logic          flush, pop, push;
  logic          misalign, range_bad, addr_bad;

  // 33-bit sum so a PC near the top of the address space cannot wrap into range
  assign range_bad = ({1'b0, fetch_pc} + 33'd3) >= 33'(MEM_BYTES);

`ifdef IFETCH_ALIGN_CHECK_EN
  assign misalign = (fetch_pc[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign addr_bad    = misalign || range_bad;
  assign flush       = redirect_valid && (state != IDLE);
  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready && !flush;
  assign push        = (state == RUN) && !redirect_valid && !addr_bad &&
                       ((count < CW'(QDEPTH)) || pop);
  assign wr_idx      = pop ? (count - CW'(1)) : count;

  assign imem_addr  = fetch_pc;
  assign instr_data = q_data[0];
  assign instr_pc   = q_pc[0];
  assign busy       = (state == RUN);
  assign fault      = (state == FAULT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (redirect_valid) begin
          fetch_pc_nxt = redirect_pc;
        end else if (addr_bad) begin
          state_nxt = FAULT;
        end else if (push) begin
          fetch_pc_nxt = fetch_pc + 32'd4;
        end
      end
      FAULT: begin
        if (redirect_valid) begin
          state_nxt    = RUN;
          fetch_pc_nxt = redirect_pc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_pc    <= 32'd0;
      fault_cause <= 2'b00;
    end else if ((state == RUN) && !redirect_valid && addr_bad) begin
      fault_pc    <= fetch_pc;
      fault_cause <= misalign ? 2'b01 : 2'b10;
    end else if ((state == FAULT) && redirect_valid) begin
      fault_pc    <= 32'd0;
      fault_cause <= 2'b00;
    end
  end

  // Shift queue with slot 0 as head; slots are never cleared on pop/flush so the head holds its last value
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_data[i] <= 32'd0;
        q_pc[i]   <= 32'd0;
      end
    end else if (flush) begin
      count <= '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < QDEPTH - 1; i++) begin
          if (CW'(i + 1) < count) begin
            q_data[i] <= q_data[i+1];
            q_pc[i]   <= q_pc[i+1];
          end
        end
      end
      if (push) begin
        for (int i = 0; i < QDEPTH; i++) begin
          if (CW'(i) == wr_idx) begin
            q_data[i] <= imem_data;
            q_pc[i]   <= fetch_pc;
          end
        end
      end
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed testbench for instr_fetch_ctrl with a 28-byte memory holding 0x11111111..0x77777777.
// Honours IFETCH_ALIGN_CHECK_EN for the misaligned-redirect scenario.
module tb_instr_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        fault;
  logic [31:0] fault_pc;
  logic [1:0]  fault_cause;
  logic        busy;

  int checks;
  int failures;

  instr_fetch_ctrl #(.RESET_PC(32'd0), .MEM_BYTES(28), .QDEPTH(2)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .fault(fault), .fault_pc(fault_pc),
    .fault_cause(fault_cause), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte b of word n (address 4n..4n+3) is (n+1)*0x11; bytes past the end read as zero
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    logic [31:0] w;
    logic [31:0] a;
    w = 32'd0;
    for (int b = 0; b < 4; b++) begin
      a = addr + 32'(b);
      w = w << 8;
      if (a < 32'd28) w[7:0] = 8'(((a >> 2) + 32'd1) * 32'h11);
    end
    return w;
  endfunction

  assign imem_data = mem_word(imem_addr);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic rv, input logic [31:0] rpc, input logic rdy);
    start          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    instr_ready    = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic checkHead(input string tag, input logic [31:0] pc, input logic [31:0] data);
    checkOutput({tag, "_valid"}, 32'(instr_valid), 32'd1);
    checkOutput({tag, "_pc"},    instr_pc, pc);
    checkOutput({tag, "_data"},  instr_data, data);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    start = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    instr_ready = 1'b0;

    $display("[TB] reset and straight-line run");
    doReset();
    checkOutput("rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_addr", imem_addr, 32'd0);
    checkOutput("rst_data", instr_data, 32'd0);
    checkOutput("rst_pc", instr_pc, 32'd0);
    checkOutput("rst_fault", 32'(fault), 32'd0);
    checkOutput("rst_fault_pc", fault_pc, 32'd0);
    checkOutput("rst_cause", 32'(fault_cause), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);

    applyStimulus(1'b0, 1'b1, 32'd16, 1'b1);
    checkOutput("idle_redir_addr", imem_addr, 32'd0);
    checkOutput("idle_redir_busy", 32'(busy), 32'd0);

    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    checkOutput("start_busy", 32'(busy), 32'd1);
    checkOutput("start_valid", 32'(instr_valid), 32'd0);
    checkOutput("start_addr", imem_addr, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    for (int k = 0; k < 7; k++) begin
      checkHead($sformatf("seq%0d", k), 32'(4 * k), 32'(k + 1) * 32'h11111111);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    end
    checkOutput("end_fault", 32'(fault), 32'd1);
    checkOutput("end_fault_pc", fault_pc, 32'd28);
    checkOutput("end_cause", 32'(fault_cause), 32'd2);
    checkOutput("end_busy", 32'(busy), 32'd0);
    checkOutput("end_valid", 32'(instr_valid), 32'd0);
    checkOutput("end_hold_pc", instr_pc, 32'd24);
    checkOutput("end_hold_data", instr_data, 32'h77777777);

    $display("[TB] fault recovery");
    applyStimulus(1'b0, 1'b1, 32'd0, 1'b1);
    checkOutput("rec_fault", 32'(fault), 32'd0);
    checkOutput("rec_fault_pc", fault_pc, 32'd0);
    checkOutput("rec_cause", 32'(fault_cause), 32'd0);
    checkOutput("rec_busy", 32'(busy), 32'd1);
    checkOutput("rec_valid", 32'(instr_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    checkHead("rec_head", 32'd0, 32'h11111111);

    $display("[TB] backpressure");
    doReset();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("bp_addr", imem_addr, 32'd8);
    checkHead("bp_head", 32'd0, 32'h11111111);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("bp_addr_hold", imem_addr, 32'd8);
    for (int k = 0; k < 4; k++) begin
      checkHead($sformatf("bp_rel%0d", k), 32'(4 * k), 32'(k + 1) * 32'h11111111);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    end

    $display("[TB] redirect");
    doReset();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    checkHead("rd_pre", 32'd4, 32'h22222222);
    applyStimulus(1'b0, 1'b1, 32'd16, 1'b1);
    checkOutput("rd_bubble_valid", 32'(instr_valid), 32'd0);
    checkOutput("rd_addr", imem_addr, 32'd16);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    checkHead("rd_tgt", 32'd16, 32'h55555555);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    checkHead("rd_next", 32'd20, 32'h66666666);

    $display("[TB] misaligned redirect");
    doReset();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'd7, 1'b1);
    checkOutput("mis_valid", 32'(instr_valid), 32'd0);
    checkOutput("mis_addr", imem_addr, 32'd7);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
`ifdef IFETCH_ALIGN_CHECK_EN
    checkOutput("mis_fault", 32'(fault), 32'd1);
    checkOutput("mis_fault_pc", fault_pc, 32'd7);
    checkOutput("mis_cause", 32'(fault_cause), 32'd1);
    checkOutput("mis_no_deliver", 32'(instr_valid), 32'd0);
`else
    checkHead("mis7", 32'd7, 32'h22333333);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    checkHead("mis11", 32'd11, 32'h33444444);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    checkHead("mis15", 32'd15, 32'h44555555);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    checkHead("mis19", 32'd19, 32'h55666666);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    checkHead("mis23", 32'd23, 32'h66777777);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    checkOutput("mis_fault", 32'(fault), 32'd1);
    checkOutput("mis_fault_pc", fault_pc, 32'd27);
    checkOutput("mis_cause", 32'(fault_cause), 32'd2);
    checkOutput("mis_valid_end", 32'(instr_valid), 32'd0);
`endif

    $display("[TB] reset mid-run");
    doReset();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkHead("mid_pre", 32'd0, 32'h11111111);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    reset = 1'b0;
    checkOutput("mid_valid", 32'(instr_valid), 32'd0);
    checkOutput("mid_addr", imem_addr, 32'd0);
    checkOutput("mid_busy", 32'(busy), 32'd0);
    checkOutput("mid_data", instr_data, 32'd0);
    checkOutput("mid_pc", instr_pc, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    checkHead("mid_restart", 32'd0, 32'h11111111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
